// File: rtl/regfifo_param_pkg.sv
// Shared definitions for the parametrised register FIFO used by DMA descriptor queues:
// default geometry, legal depth range and the error code carried in the status register.
package regfifo_param_pkg;

   localparam int unsigned DmaDescWidth = 32;
   localparam int unsigned DmaDescDepth = 4;
   localparam int unsigned MinDepth     = 2;
   localparam int unsigned MaxDepth     = 16;

   typedef enum logic [1:0] {
      ErrNone      = 2'd0,
      ErrOverflow  = 2'd1,
      ErrUnderflow = 2'd2
   } fifo_err_e;

   // Overflow needs a full FIFO and underflow an empty one, so the two never coincide.
   function automatic fifo_err_e fifo_err_code(input logic ovf, input logic unf);
      if (ovf) begin
         return ErrOverflow;
      end
      if (unf) begin
         return ErrUnderflow;
      end
      return ErrNone;
   endfunction

endpackage

// File: rtl/regfifo_param_if.sv
// Push/pop/status bundle of the register FIFO; master drives requests, slave is the FIFO.
interface regfifo_param_if
   import regfifo_param_pkg::*;
#(
   parameter int unsigned WIDTH = DmaDescWidth,
   parameter int unsigned DEPTH = DmaDescDepth
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             wr_en;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/regfifo_param.sv
// First-word-fall-through register FIFO: entry[0] is always the head, pops shift the array
// down by one, pushes land at entry[count]. Flags decode combinationally from the count.
module regfifo_param
   import regfifo_param_pkg::*;
#(
   parameter int unsigned WIDTH    = DmaDescWidth,
   parameter int unsigned DEPTH    = DmaDescDepth,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1
) (
   input logic            clk,
   input logic            rst_n,
   regfifo_param_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CntFull = cnt_t'(DEPTH);

   if (DEPTH < MinDepth || DEPTH > MaxDepth) begin : g_bad_depth
      $error("regfifo_param: DEPTH %0d outside %0d..%0d", DEPTH, MinDepth, MaxDepth);
   end
   if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("regfifo_param: AF_LEVEL %0d exceeds DEPTH %0d", AF_LEVEL, DEPTH);
   end

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [WIDTH-1:0] entry_d [DEPTH];
   cnt_t             count_q, count_d;
   fifo_err_e        err_q, err_d;
   logic             rd_ok, wr_ok;

   // Slots at or above count always hold zero: pops shift zero into the top, and pushes only
   // ever fill the first free slot.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] shift_in;

      if (i < DEPTH - 1) begin : g_mid
         assign shift_in = entry_q[i+1];
      end else begin : g_top
         assign shift_in = '0;
      end

      assign entry_d[i] = bus.flush                              ? '0         :
                          rd_ok ? ((wr_ok && count_q == cnt_t'(i + 1)) ? bus.din : shift_in) :
                          (wr_ok && count_q == cnt_t'(i))        ? bus.din    :
                                                                   entry_q[i];
   end

   always_comb begin
      rd_ok   = bus.rd_en && (count_q != '0);
      // A push into a full FIFO is still taken when a pop frees the tail slot this cycle.
      wr_ok   = bus.wr_en && ((count_q != CntFull) || rd_ok);
      count_d = count_q;
      err_d   = ErrNone;

      if (bus.flush) begin
         count_d = '0;
      end else begin
         if (wr_ok && !rd_ok) begin
            count_d = count_q + cnt_t'(1);
         end else if (rd_ok && !wr_ok) begin
            count_d = count_q - cnt_t'(1);
         end
         err_d = fifo_err_code(bus.wr_en && !wr_ok, bus.rd_en && (count_q == '0));
      end

      bus.dout         = entry_q[0];
      bus.count        = count_q;
      bus.full         = (count_q == CntFull);
      bus.empty        = (count_q == '0);
      bus.almost_full  = (32'(count_q) >= AF_LEVEL);
      bus.almost_empty = (32'(count_q) <= AE_LEVEL);
      bus.overflow     = (err_q == ErrOverflow);
      bus.underflow    = (err_q == ErrUnderflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= ErrNone;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
         entry_q <= entry_d;
      end
   end

   count_in_range_a: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntFull);

endmodule

// File: tb/tb_regfifo_param.sv
// Directed and scoreboarded checks of regfifo_param at WIDTH=32, DEPTH=4.
module tb_regfifo_param;

   localparam int unsigned W = 32;
   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   regfifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

   regfifo_param #(
      .WIDTH   (W),
      .DEPTH   (D),
      .AF_LEVEL(3),
      .AE_LEVEL(1)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
   endtask

   task automatic push(input logic [31:0] d);
      bus.wr_en = 1'b1;
      bus.din   = d;
      cyc();
      bus.wr_en = 1'b0;
   endtask

   task automatic drain4(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp[0] = e0;
      exp[1] = e1;
      exp[2] = e2;
      exp[3] = e3;
      bus.rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("drain_dout%0d", k), bus.dout, exp[k]);
         cyc();
      end
      bus.rd_en = 1'b0;
      check_eq("drain_empty", 32'(bus.empty), 32'd1);
      check_eq("drain_count", 32'(bus.count), 32'd0);
      check_eq("drain_unf", 32'(bus.underflow), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] wr_data [4];
      logic        exp_af  [4];
      logic        exp_ae  [4];
      logic        exp_fl  [4];
      logic [31:0] q [$];

      wr_data = '{32'h11, 32'h22, 32'h33, 32'h44};
      exp_af  = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_ae  = '{1'b1, 1'b0, 1'b0, 1'b0};
      exp_fl  = '{1'b0, 1'b0, 1'b0, 1'b1};

      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11;
      check_eq("rst_count", 32'(bus.count), 32'd0);
      check_eq("rst_empty", 32'(bus.empty), 32'd1);
      check_eq("rst_full", 32'(bus.full), 32'd0);
      check_eq("rst_ae", 32'(bus.almost_empty), 32'd1);
      check_eq("rst_af", 32'(bus.almost_full), 32'd0);
      check_eq("rst_dout", bus.dout, 32'd0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rst_unf", 32'(bus.underflow), 32'd0);
      rst_n = 1'b1;
      cyc();

      for (int k = 0; k < 4; k++) begin
         push(wr_data[k]);
         check_eq($sformatf("fill_count%0d", k), 32'(bus.count), 32'(k + 1));
         check_eq($sformatf("fill_dout%0d", k), bus.dout, 32'h11);
         check_eq($sformatf("fill_af%0d", k), 32'(bus.almost_full), 32'(exp_af[k]));
         check_eq($sformatf("fill_ae%0d", k), 32'(bus.almost_empty), 32'(exp_ae[k]));
         check_eq($sformatf("fill_full%0d", k), 32'(bus.full), 32'(exp_fl[k]));
      end

      push(32'h55);
      check_eq("ovf_pulse", 32'(bus.overflow), 32'd1);
      check_eq("ovf_count", 32'(bus.count), 32'd4);
      cyc();
      check_eq("ovf_pulse_end", 32'(bus.overflow), 32'd0);
      drain4(32'h11, 32'h22, 32'h33, 32'h44);

      for (int k = 0; k < 4; k++) begin
         push(wr_data[k]);
      end
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 32'h55;
      cyc();
      idle();
      check_eq("rdwr_full_count", 32'(bus.count), 32'd4);
      check_eq("rdwr_full_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rdwr_full_dout", bus.dout, 32'h22);
      drain4(32'h22, 32'h33, 32'h44, 32'h55);

      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.din   = 32'hAA;
      cyc();
      idle();
      check_eq("unf_pulse", 32'(bus.underflow), 32'd1);
      check_eq("unf_count", 32'(bus.count), 32'd1);
      check_eq("unf_dout", bus.dout, 32'hAA);
      cyc();
      check_eq("unf_pulse_end", 32'(bus.underflow), 32'd0);
      bus.rd_en = 1'b1;
      cyc();
      bus.rd_en = 1'b0;
      check_eq("unf_pop_count", 32'(bus.count), 32'd0);

      push(32'h1);
      push(32'h2);
      push(32'h3);
      bus.flush = 1'b1;
      bus.wr_en = 1'b1;
      bus.din   = 32'h77;
      cyc();
      idle();
      check_eq("flush_count", 32'(bus.count), 32'd0);
      check_eq("flush_empty", 32'(bus.empty), 32'd1);
      check_eq("flush_dout", bus.dout, 32'd0);
      check_eq("flush_ovf", 32'(bus.overflow), 32'd0);
      check_eq("flush_unf", 32'(bus.underflow), 32'd0);

      push(32'h5A);
      push(32'hA5);
      check_eq("prerst_count", 32'(bus.count), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      check_eq("async_rst_count", 32'(bus.count), 32'd0);
      check_eq("async_rst_empty", 32'(bus.empty), 32'd1);
      check_eq("async_rst_dout", bus.dout, 32'd0);
      #2 rst_n = 1'b1;
      cyc();

      for (int n = 0; n < 10000; n++) begin
         logic wr, rd, fl, rd_ok, wr_ok, e_ovf, e_unf;
         logic [31:0] d;
         wr = ($urandom_range(0, 99) < 55);
         rd = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 2);
         d  = $urandom;
         bus.wr_en = wr;
         bus.rd_en = rd;
         bus.flush = fl;
         bus.din   = d;
         rd_ok = rd && (q.size() != 0);
         wr_ok = wr && ((q.size() != D) || rd_ok);
         e_ovf = !fl && wr && !wr_ok;
         e_unf = !fl && rd && (q.size() == 0);
         if (fl) begin
            q.delete();
         end else begin
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
         end
         cyc();
         check_eq("rnd_count", 32'(bus.count), 32'(q.size()));
         check_eq("rnd_full", 32'(bus.full), 32'(q.size() == D));
         check_eq("rnd_empty", 32'(bus.empty), 32'(q.size() == 0));
         check_eq("rnd_af", 32'(bus.almost_full), 32'(q.size() >= 3));
         check_eq("rnd_ae", 32'(bus.almost_empty), 32'(q.size() <= 1));
         check_eq("rnd_ovf", 32'(bus.overflow), 32'(e_ovf));
         check_eq("rnd_unf", 32'(bus.underflow), 32'(e_unf));
         if (q.size() != 0) begin
            check_eq("rnd_dout", bus.dout, q[0]);
         end
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
